sal_ddr2_cmd_sched: RTL and testbench
=====================================

// Module: sal_ddr2_cmd_sched
// PURPOSE
//  Per-cycle DDR2 command scheduler between the BK_CNT bank controllers and the DFI control port.
//  Each cycle it picks at most one bank command (ACT/RD/WR/PRE) or a refresh.
//  Enforces inter-bank timing (tRRD, tCCD, tWTR, tRTW) and sequences refresh (drain, REF, tRFC).
//  Bank-local timing (tRCD, tRP, tRAS) remains the bank controllers' duty.
// PARAMETERS
//  BK_CNT   8   number of banks / requesters
//  BA_W     3   bank address width (clog2 BK_CNT)
//  ADDR_W   14  DRAM address width (row; column zero-extended)
//  T_RRD    2   min cycles ACT->ACT, any banks
//  T_CCD    2   min cycles RD/WR->RD/WR
//  T_WTR    3   min cycles WR->RD
//  T_RTW    4   min cycles RD->WR
//  T_RFC    26  cycles REF->next command
//  TIMER_W  5   timer width; must hold max(T_*)
// PORTS
//  clk            in   1               clock
//  rst            in   1               asynchronous reset, active-high
//  bk_act_req     in   BK_CNT          per-bank ACT request
//  bk_rd_req      in   BK_CNT          per-bank RD request
//  bk_wr_req      in   BK_CNT          per-bank WR request
//  bk_pre_req     in   BK_CNT          per-bank PRE request
//  bk_addr        in   BK_CNT*ADDR_W   per-bank row (ACT) or column (RD/WR)
//  bk_gnt         out  BK_CNT          one-hot grant, combinational, same cycle as request
//  ref_req        in   1               refresh request, level, held until ref_done
//  ref_done       out  1               1-cycle pulse when tRFC expires
//  dfi_cmd_valid  out  1               registered: command valid this cycle
//  dfi_cmd        out  3               {ras_n,cas_n,we_n} (encodings in package)
//  dfi_ba         out  BA_W            bank address
//  dfi_addr       out  ADDR_W          row/column address
// BEHAVIOUR
//  Reset: bk_gnt=0, ref_done=0, dfi_cmd_valid=0, dfi_cmd=NOP, dfi_ba=0, dfi_addr=0.
//   Reset also sets all timers=0, all RR pointers=0, FSM=NORM. Holds for reset asserted mid-refresh.
//  Latency: request in cycle N -> bk_gnt in cycle N -> DFI command registered in cycle N+1.
//   Bank must drop the granted request in N+1; no repeat grant comes from a stale request.
//  Bank rule: each bank asserts at most one of act/rd/wr/pre. Multiple asserted = illegal (SVA).
//  Class priority: CAS (RD|WR) > ACT > PRE. Row hits go first.
//  Within a class: round-robin. Class pointer moves to granted bank+1 modulo BK_CNT. Other pointers hold.
//  Eligibility (timer==0):
//   ACT  needs rrd_cnt.
//   RD   needs ccd_cnt and wtr_cnt.
//   WR   needs ccd_cnt and rtw_cnt.
//   PRE  always eligible.
//   If the top class has no eligible bank, the next class is considered in the same cycle.
//  Timers (TIMER_W, count down, saturate at 0): on issue, load T_x-1.
//   ACT loads rrd. RD loads ccd, rtw. WR loads ccd, wtr. REF loads rfc.
//   A new load overrides an in-flight count.
//  No eligible request: dfi_cmd_valid=0, dfi_cmd=NOP. dfi_ba and dfi_addr hold their last value.
//  FSM:
//   NORM  -> DRAIN when ref_req=1, sampled before arbitration. A bank grant in that same cycle is suppressed.
//   DRAIN: no grants. -> REF when rrd, ccd, wtr, rtw timers are all 0.
//    Refresh controller guarantees all banks precharged.
//   REF: issue REF 1 cycle (dfi_cmd_valid=1, cmd=REF, ba=0, addr=0), load rfc=T_RFC-1. -> RFC.
//   RFC: no grants. At rfc==0, pulse ref_done. -> NORM.
//  ref_req deasserted in DRAIN: unsupported, flagged by SVA. FSM proceeds anyway.
//  Pointer wrap: bank BK_CNT-1 granted -> pointer=0.
// STRUCTURE
//  Package sal_ddr2_sched_pkg:
//   cmd_t enum: NOP=3'b111, ACT=3'b011, RD=3'b101, WR=3'b100, PRE=3'b010, REF=3'b001.
//   sched_state_t enum: NORM, DRAIN, REF, RFC.
//  Sub-module sal_rr_arbiter #(N): req[N], ptr -> one-hot gnt, gnt_idx, any.
//   Instantiated 3 times (CAS, ACT, PRE); pointer update in parent.
// TESTING
//  1 Reset: rst=1 with all requests high -> bk_gnt=0, dfi_cmd_valid=0, dfi_cmd=3'b111.
//  2 RR fairness: ACT on banks 0,3,5 held continuously, T_RRD=2
//     -> grants 0,3,5,0 on cycles 0,2,4,6; DFI one cycle later.
//  3 Priority: bank1 RD and bank2 ACT, same cycle -> bank1 granted, RD issued.
//     bank2 ACT granted next cycle (rrd=0).
//  4 Turnaround: WR bank0 at cycle 0, RD bank1 pending -> RD granted no earlier than cycle 3.
//     WR then RD repeated with T_WTR=3 checks the same bound.
//  5 Refresh: ref_req at cycle 10 with ACT pending
//     -> no grant; REF issued once timers clear; ref_done exactly T_RFC cycles later.
//     Pending ACT granted the cycle after ref_done.
//  6 Reset mid-RFC: rst pulse during RFC -> FSM=NORM, no ref_done, outputs at reset values.

Source files
------------

// File: rtl/sal_ddr2_sched_pkg.sv
// Shared types for the DDR2 command scheduler: DFI command encodings and scheduler FSM states.
package sal_ddr2_sched_pkg;

  // {ras_n, cas_n, we_n}
  typedef enum logic [2:0] {
    CMD_NOP = 3'b111,
    CMD_ACT = 3'b011,
    CMD_RD  = 3'b101,
    CMD_WR  = 3'b100,
    CMD_PRE = 3'b010,
    CMD_REF = 3'b001
  } cmd_t;

  typedef enum logic [1:0] {
    ST_NORM  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_REF   = 2'd2,
    ST_RFC   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/sal_rr_arbiter.sv
// Round-robin pick among N requesters: first set request at or after ptr, wrapping to 0.
module sal_rr_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    // upper segment [ptr, N-1] first, then the wrapped segment [0, ptr-1]
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (i >= int'(ptr))) begin
        gnt[i]  = 1'b1;
        gnt_idx = IDX_W'(i);
        any     = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any && req[i]) begin
        gnt[i]  = 1'b1;
        gnt_idx = IDX_W'(i);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sal_ddr2_cmd_sched.sv
// DDR2 command scheduler: one bank command (CAS > ACT > PRE, round-robin within class) or a
// refresh per cycle, enforcing inter-bank tRRD/tCCD/tWTR/tRTW and refresh drain/tRFC.
module sal_ddr2_cmd_sched
  import sal_ddr2_sched_pkg::*;
#(
  parameter int BK_CNT  = 8,
  parameter int BA_W    = 3,
  parameter int ADDR_W  = 14,
  parameter int T_RRD   = 2,
  parameter int T_CCD   = 2,
  parameter int T_WTR   = 3,
  parameter int T_RTW   = 4,
  parameter int T_RFC   = 26,
  parameter int TIMER_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BK_CNT-1:0]        bk_act_req,
  input  logic [BK_CNT-1:0]        bk_rd_req,
  input  logic [BK_CNT-1:0]        bk_wr_req,
  input  logic [BK_CNT-1:0]        bk_pre_req,
  input  logic [BK_CNT*ADDR_W-1:0] bk_addr,
  output logic [BK_CNT-1:0]        bk_gnt,
  input  logic                     ref_req,
  output logic                     ref_done,
  output logic                     dfi_cmd_valid,
  output logic [2:0]               dfi_cmd,
  output logic [BA_W-1:0]          dfi_ba,
  output logic [ADDR_W-1:0]        dfi_addr
);

  localparam logic [TIMER_W-1:0] RRD_LD = TIMER_W'(T_RRD - 1);
  localparam logic [TIMER_W-1:0] CCD_LD = TIMER_W'(T_CCD - 1);
  localparam logic [TIMER_W-1:0] WTR_LD = TIMER_W'(T_WTR - 1);
  localparam logic [TIMER_W-1:0] RTW_LD = TIMER_W'(T_RTW - 1);
  localparam logic [TIMER_W-1:0] RFC_LD = TIMER_W'(T_RFC - 1);

  sched_state_t        state_q, state_d;
  logic [TIMER_W-1:0]  rrd_q, rrd_d, ccd_q, ccd_d, wtr_q, wtr_d, rtw_q, rtw_d, rfc_q, rfc_d;
  logic [BA_W-1:0]     cas_ptr_q, cas_ptr_d, act_ptr_q, act_ptr_d, pre_ptr_q, pre_ptr_d;
  logic                dfi_vld_q, dfi_vld_d;
  cmd_t                dfi_cmd_q, dfi_cmd_d;
  logic [BA_W-1:0]     dfi_ba_q, dfi_ba_d;
  logic [ADDR_W-1:0]   dfi_addr_q, dfi_addr_d;
  logic [BK_CNT-1:0]   gnt_c;
  logic                ref_done_c;

  logic [ADDR_W-1:0]   addr_a [BK_CNT];
  logic                rd_ok, wr_ok, act_ok;
  logic [BK_CNT-1:0]   cas_elig, act_elig;
  logic [BK_CNT-1:0]   cas_gnt, act_gnt, pre_gnt;
  logic [BA_W-1:0]     cas_idx, act_idx, pre_idx;
  logic                cas_any, act_any, pre_any;

  for (genvar b = 0; b < BK_CNT; b++) begin : g_addr
    assign addr_a[b] = bk_addr[b*ADDR_W +: ADDR_W];
  end

  assign rd_ok    = (ccd_q == '0) && (wtr_q == '0);
  assign wr_ok    = (ccd_q == '0) && (rtw_q == '0);
  assign act_ok   = (rrd_q == '0);
  assign cas_elig = (bk_rd_req & {BK_CNT{rd_ok}}) | (bk_wr_req & {BK_CNT{wr_ok}});
  assign act_elig = bk_act_req & {BK_CNT{act_ok}};

  sal_rr_arbiter #(.N(BK_CNT), .IDX_W(BA_W)) u_cas_arb (
    .req(cas_elig), .ptr(cas_ptr_q), .gnt(cas_gnt), .gnt_idx(cas_idx), .any(cas_any));
  sal_rr_arbiter #(.N(BK_CNT), .IDX_W(BA_W)) u_act_arb (
    .req(act_elig), .ptr(act_ptr_q), .gnt(act_gnt), .gnt_idx(act_idx), .any(act_any));
  sal_rr_arbiter #(.N(BK_CNT), .IDX_W(BA_W)) u_pre_arb (
    .req(bk_pre_req), .ptr(pre_ptr_q), .gnt(pre_gnt), .gnt_idx(pre_idx), .any(pre_any));

  function automatic logic [BA_W-1:0] ptr_after(input logic [BA_W-1:0] idx);
    return (int'(idx) == BK_CNT - 1) ? '0 : idx + 1'b1;
  endfunction

  function automatic logic [TIMER_W-1:0] dec(input logic [TIMER_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  always_comb begin
    state_d    = state_q;
    rrd_d      = dec(rrd_q);
    ccd_d      = dec(ccd_q);
    wtr_d      = dec(wtr_q);
    rtw_d      = dec(rtw_q);
    rfc_d      = dec(rfc_q);
    cas_ptr_d  = cas_ptr_q;
    act_ptr_d  = act_ptr_q;
    pre_ptr_d  = pre_ptr_q;
    gnt_c      = '0;
    ref_done_c = 1'b0;
    dfi_vld_d  = 1'b0;
    dfi_cmd_d  = CMD_NOP;
    dfi_ba_d   = dfi_ba_q;
    dfi_addr_d = dfi_addr_q;
    case (state_q)
      ST_NORM: begin
        // refresh request wins over any bank grant in the same cycle
        if (ref_req) begin
          state_d = ST_DRAIN;
        end else if (cas_any) begin
          gnt_c      = cas_gnt;
          dfi_vld_d  = 1'b1;
          dfi_ba_d   = cas_idx;
          dfi_addr_d = addr_a[cas_idx];
          ccd_d      = CCD_LD;
          cas_ptr_d  = ptr_after(cas_idx);
          if (bk_rd_req[cas_idx]) begin
            dfi_cmd_d = CMD_RD;
            rtw_d     = RTW_LD;
          end else begin
            dfi_cmd_d = CMD_WR;
            wtr_d     = WTR_LD;
          end
        end else if (act_any) begin
          gnt_c      = act_gnt;
          dfi_vld_d  = 1'b1;
          dfi_cmd_d  = CMD_ACT;
          dfi_ba_d   = act_idx;
          dfi_addr_d = addr_a[act_idx];
          rrd_d      = RRD_LD;
          act_ptr_d  = ptr_after(act_idx);
        end else if (pre_any) begin
          gnt_c      = pre_gnt;
          dfi_vld_d  = 1'b1;
          dfi_cmd_d  = CMD_PRE;
          dfi_ba_d   = pre_idx;
          dfi_addr_d = addr_a[pre_idx];
          pre_ptr_d  = ptr_after(pre_idx);
        end
      end
      ST_DRAIN: begin
        if ((rrd_q == '0) && (ccd_q == '0) && (wtr_q == '0) && (rtw_q == '0)) state_d = ST_REF;
      end
      ST_REF: begin
        dfi_vld_d  = 1'b1;
        dfi_cmd_d  = CMD_REF;
        dfi_ba_d   = '0;
        dfi_addr_d = '0;
        rfc_d      = RFC_LD;
        state_d    = ST_RFC;
      end
      ST_RFC: begin
        if (rfc_q == '0) begin
          ref_done_c = 1'b1;
          state_d    = ST_NORM;
        end
      end
      default: state_d = ST_NORM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_NORM;
      rrd_q      <= '0;
      ccd_q      <= '0;
      wtr_q      <= '0;
      rtw_q      <= '0;
      rfc_q      <= '0;
      cas_ptr_q  <= '0;
      act_ptr_q  <= '0;
      pre_ptr_q  <= '0;
      dfi_vld_q  <= 1'b0;
      dfi_cmd_q  <= CMD_NOP;
      dfi_ba_q   <= '0;
      dfi_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      rrd_q      <= rrd_d;
      ccd_q      <= ccd_d;
      wtr_q      <= wtr_d;
      rtw_q      <= rtw_d;
      rfc_q      <= rfc_d;
      cas_ptr_q  <= cas_ptr_d;
      act_ptr_q  <= act_ptr_d;
      pre_ptr_q  <= pre_ptr_d;
      dfi_vld_q  <= dfi_vld_d;
      dfi_cmd_q  <= dfi_cmd_d;
      dfi_ba_q   <= dfi_ba_d;
      dfi_addr_q <= dfi_addr_d;
    end
  end

  // grant and refresh-done are combinational, so mask them while reset is held
  assign bk_gnt        = rst ? '0 : gnt_c;
  assign ref_done      = rst ? 1'b0 : ref_done_c;
  assign dfi_cmd_valid = dfi_vld_q;
  assign dfi_cmd       = dfi_cmd_q;
  assign dfi_ba        = dfi_ba_q;
  assign dfi_addr      = dfi_addr_q;

  for (genvar b = 0; b < BK_CNT; b++) begin : g_sva
    a_one_cmd: assert property (@(posedge clk) disable iff (rst)
      $onehot0({bk_act_req[b], bk_rd_req[b], bk_wr_req[b], bk_pre_req[b]}));
  end
  a_ref_held: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_DRAIN) |-> ref_req);

endmodule

// File: tb/tb_sal_ddr2_cmd_sched.sv
// Directed bench for sal_ddr2_cmd_sched: arbitration order, timing gaps, refresh, reset.
module tb_sal_ddr2_cmd_sched;
  localparam int BK = 8;
  localparam int AW = 14;

  logic            clk = 1'b0;
  logic            rst;
  logic [BK-1:0]   act, rd, wr, pre;
  logic [BK*AW-1:0] addr;
  logic            ref_req;
  logic [BK-1:0]   bk_gnt;
  logic            ref_done, dfi_cmd_valid;
  logic [2:0]      dfi_cmd;
  logic [2:0]      dfi_ba;
  logic [AW-1:0]   dfi_addr;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sal_ddr2_cmd_sched dut (
    .clk(clk), .rst(rst),
    .bk_act_req(act), .bk_rd_req(rd), .bk_wr_req(wr), .bk_pre_req(pre),
    .bk_addr(addr), .bk_gnt(bk_gnt),
    .ref_req(ref_req), .ref_done(ref_done),
    .dfi_cmd_valid(dfi_cmd_valid), .dfi_cmd(dfi_cmd), .dfi_ba(dfi_ba), .dfi_addr(dfi_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] a_of(input int b);
    return AW'(b * 16 + 5);
  endfunction

  task automatic clr();
    act = '0; rd = '0; wr = '0; pre = '0; ref_req = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic chk_dfi(input string tag, input logic [2:0] cmd, input logic [2:0] ba,
                         input logic [AW-1:0] ad);
    chk({tag, "_vld"}, 32'(dfi_cmd_valid), 32'd1);
    chk({tag, "_cmd"}, 32'(dfi_cmd), 32'(cmd));
    chk({tag, "_ba"}, 32'(dfi_ba), 32'(ba));
    chk({tag, "_addr"}, 32'(dfi_addr), 32'(ad));
  endtask

  initial begin
    logic [BK-1:0] eg;
    int done_cyc, ref_cyc, ref_cnt, bad_gnt, rd_cnt;
    for (int i = 0; i < BK; i++) addr[i*AW +: AW] = a_of(i);

    // 1: reset with every request high
    act = '1; rd = '1; wr = '1; pre = '1; ref_req = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    mid();
    chk("rst_gnt", 32'(bk_gnt), 32'd0);
    chk("rst_vld", 32'(dfi_cmd_valid), 32'd0);
    chk("rst_cmd", 32'(dfi_cmd), 32'h7);
    chk("rst_ba", 32'(dfi_ba), 32'd0);
    chk("rst_addr", 32'(dfi_addr), 32'd0);
    chk("rst_done", 32'(ref_done), 32'd0);
    clr();
    @(posedge clk); #1 rst = 1'b0;

    // 2: ACT round-robin over banks 0,3,5 with tRRD=2
    do_reset();
    act = 8'b0010_1001;
    for (int c = 0; c < 8; c++) begin
      case (c)
        0, 6:    eg = 8'b0000_0001;
        2:       eg = 8'b0000_1000;
        4:       eg = 8'b0010_0000;
        default: eg = 8'b0;
      endcase
      mid();
      chk($sformatf("rr_gnt_c%0d", c), 32'(bk_gnt), 32'(eg));
      nxt();
      chk($sformatf("rr_vld_c%0d", c), 32'(dfi_cmd_valid), 32'(eg != 0));
      if (c == 4) chk_dfi("rr_dfi_c4", 3'b011, 3'd5, a_of(5));
    end
    chk("rr_idle_cmd", 32'(dfi_cmd), 32'h7);
    chk("rr_addr_hold", 32'(dfi_addr), 32'(a_of(0)));
    chk("rr_ba_hold", 32'(dfi_ba), 32'd0);
    clr();

    // 3: CAS beats ACT; then ACT; then PRE falls through while tRRD blocks ACT
    do_reset();
    rd[1] = 1'b1; act[2] = 1'b1;
    mid(); chk("pri_gnt_rd", 32'(bk_gnt), 32'h02);
    nxt(); chk_dfi("pri_rd", 3'b101, 3'd1, a_of(1));
    rd[1] = 1'b0;
    mid(); chk("pri_gnt_act", 32'(bk_gnt), 32'h04);
    nxt(); chk_dfi("pri_act", 3'b011, 3'd2, a_of(2));
    act[2] = 1'b0; act[6] = 1'b1; pre[4] = 1'b1;
    mid(); chk("pri_gnt_pre", 32'(bk_gnt), 32'h10);
    nxt(); chk_dfi("pri_pre", 3'b010, 3'd4, a_of(4));
    pre[4] = 1'b0;
    mid(); chk("pri_gnt_act6", 32'(bk_gnt), 32'h40);
    nxt(); clr();

    // 4: WR->RD (tWTR=3), RD->WR (tRTW=4), WR->RD again
    do_reset();
    wr[0] = 1'b1; rd[1] = 1'b1;
    mid(); chk("ta_gnt_wr", 32'(bk_gnt), 32'h01);
    nxt(); chk_dfi("ta_wr", 3'b100, 3'd0, a_of(0));
    wr[0] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      mid(); chk($sformatf("ta_wtr_c%0d", c), 32'(bk_gnt), (c == 3) ? 32'h02 : 32'h0);
      nxt();
    end
    chk_dfi("ta_rd", 3'b101, 3'd1, a_of(1));
    rd[1] = 1'b0; wr[2] = 1'b1;
    for (int c = 4; c <= 7; c++) begin
      mid(); chk($sformatf("ta_rtw_c%0d", c), 32'(bk_gnt), (c == 7) ? 32'h04 : 32'h0);
      nxt();
    end
    chk_dfi("ta_wr2", 3'b100, 3'd2, a_of(2));
    wr[2] = 1'b0; rd[3] = 1'b1;
    for (int c = 8; c <= 10; c++) begin
      mid(); chk($sformatf("ta_wtr2_c%0d", c), 32'(bk_gnt), (c == 10) ? 32'h08 : 32'h0);
      nxt();
    end
    clr();

    // 5: refresh at cycle 10 after a WR at cycle 9, ACT bank7 pending throughout
    do_reset();
    repeat (9) nxt();
    wr[0] = 1'b1;
    nxt();
    wr[0] = 1'b0; ref_req = 1'b1; act[7] = 1'b1;
    done_cyc = -1; ref_cyc = -1; ref_cnt = 0; bad_gnt = 0;
    for (int c = 10; c < 80 && done_cyc < 0; c++) begin
      mid();
      if (bk_gnt != 0) bad_gnt++;
      if (ref_done) done_cyc = c;
      nxt();
      if (dfi_cmd_valid && dfi_cmd == 3'b001) begin
        ref_cnt++;
        ref_cyc = c;
        chk("ref_ba", 32'(dfi_ba), 32'd0);
        chk("ref_addr", 32'(dfi_addr), 32'd0);
      end
      if (done_cyc >= 0) ref_req = 1'b0;
    end
    chk("ref_no_gnt", 32'(bad_gnt), 32'd0);
    chk("ref_count", 32'(ref_cnt), 32'd1);
    chk("ref_issue_cyc", 32'(ref_cyc), 32'd13);
    chk("ref_done_cyc", 32'(done_cyc), 32'd39);
    mid();
    chk("ref_act_after", 32'(bk_gnt), 32'h80);
    chk("ref_done_low", 32'(ref_done), 32'd0);
    nxt(); clr();

    // 6: reset pulse while in RFC
    do_reset();
    ref_req = 1'b1;
    repeat (6) nxt();
    rst = 1'b1; ref_req = 1'b0; act[1] = 1'b1;
    mid();
    chk("mid_gnt", 32'(bk_gnt), 32'd0);
    chk("mid_vld", 32'(dfi_cmd_valid), 32'd0);
    chk("mid_cmd", 32'(dfi_cmd), 32'h7);
    chk("mid_ba", 32'(dfi_ba), 32'd0);
    chk("mid_addr", 32'(dfi_addr), 32'd0);
    chk("mid_done", 32'(ref_done), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    mid(); chk("mid_norm_gnt", 32'(bk_gnt), 32'h02);
    nxt(); act[1] = 1'b0;
    rd_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      mid();
      if (ref_done) rd_cnt++;
      nxt();
    end
    chk("mid_no_done", 32'(rd_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
